// File: rtl/axil_slave_bridge_pkg.sv
// Shared definitions for the AXI4-Lite slave bridge: response codes and
// the state encodings of the independent write and read controllers.
package axil_slave_bridge_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      W_IDLE  = 2'd0,
      W_ISSUE = 2'd1,
      W_WAIT  = 2'd2,
      W_RESP  = 2'd3
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_ISSUE = 2'd1,
      R_WAIT  = 2'd2,
      R_RESP  = 2'd3
   } rd_state_t;

endpackage

// File: rtl/axil_slave_bridge_timeout_cnt.sv
// Saturating cycle counter used to bound the wait for the user side.
// Held at zero while clr is high; expired flags once TIMEOUT_CYC cycles
// have been counted. TIMEOUT_CYC = 0 disables expiry entirely.
module axil_timeout_cnt #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

   logic [CW-1:0] cnt;

   // Count enabled cycles, stopping at the limit so expiry stays asserted.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != LIMIT)) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired = (TIMEOUT_CYC > 0) && (cnt == LIMIT);

endmodule

// File: rtl/axil_slave_bridge.sv
// AXI4-Lite slave bridge: decodes a base/span region, turns each accepted
// write or read into a single-cycle user strobe, waits a variable number
// of cycles for the user acknowledge (bounded by a timeout that yields
// SLVERR), and holds every response until the master accepts it.
module axil_slave_bridge
   import axil_slave_bridge_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    ADDR_SPAN   = 4096,
   parameter int                    TIMEOUT_CYC = 64
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   // write address / data / response
   input  logic [ADDR_WIDTH-1:0]     awaddr,
   input  logic                      awvalid,
   output logic                      awready,
   input  logic [DATA_WIDTH-1:0]     wdata,
   input  logic [DATA_WIDTH/8-1:0]   wstrb,
   input  logic                      wvalid,
   output logic                      wready,
   output logic [1:0]                bresp,
   output logic                      bvalid,
   input  logic                      bready,
   // read address / data
   input  logic [ADDR_WIDTH-1:0]     araddr,
   input  logic                      arvalid,
   output logic                      arready,
   output logic [DATA_WIDTH-1:0]     rdata,
   output logic [1:0]                rresp,
   output logic                      rvalid,
   input  logic                      rready,
   // user write side
   output logic [ADDR_WIDTH-1:0]     user_wr_addr,
   output logic [DATA_WIDTH-1:0]     user_wr_data,
   output logic [DATA_WIDTH/8-1:0]   user_wr_strb,
   output logic                      user_wr_en,
   input  logic                      user_wr_ack,
   input  logic [1:0]                user_wr_resp,
   // user read side
   output logic [ADDR_WIDTH-1:0]     user_rd_addr,
   output logic                      user_rd_en,
   input  logic                      user_rd_valid,
   input  logic [DATA_WIDTH-1:0]     user_rd_data,
   input  logic [1:0]                user_rd_resp
);

   localparam int OFF_W  = $clog2(ADDR_SPAN);
   localparam int STRB_W = DATA_WIDTH / 8;

   // Region hit: the bits above the span offset must match the base.
   function automatic logic in_region(input logic [ADDR_WIDTH-1:0] a);
      return a[ADDR_WIDTH-1:OFF_W] == BASE_ADDR[ADDR_WIDTH-1:OFF_W];
   endfunction

   // Offset inside the region, zero-extended to the full address width.
   function automatic logic [ADDR_WIDTH-1:0] region_offset(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] o;
      o            = '0;
      o[OFF_W-1:0] = a[OFF_W-1:0];
      return o;
   endfunction

   // ---------------------------------------------------------------- write
   wr_state_t             wr_state;
   logic                  aw_full;
   logic                  w_full;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_W-1:0]     w_strb_q;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  aw_have;
   logic                  w_have;
   logic [ADDR_WIDTH-1:0] wr_addr_sel;
   logic [DATA_WIDTH-1:0] wr_data_sel;
   logic [STRB_W-1:0]     wr_strb_sel;
   logic                  wr_to_run;
   logic                  wr_to_expired;

   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid  && wready;
   // A half counts as present if held already or arriving this cycle.
   assign aw_have = aw_full || aw_hs;
   assign w_have  = w_full  || w_hs;

   assign wr_addr_sel = aw_hs ? awaddr : aw_addr_q;
   assign wr_data_sel = w_hs  ? wdata  : w_data_q;
   assign wr_strb_sel = w_hs  ? wstrb  : w_strb_q;

   assign wr_to_run = (wr_state == W_ISSUE) || (wr_state == W_WAIT);

   axil_timeout_cnt #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wr_timeout (
      .aclk    (aclk),
      .aresetn (aresetn),
      .clr     (!wr_to_run),
      .en      (wr_to_run),
      .expired (wr_to_expired)
   );

   // Write controller: collect AW and W in any order, issue, await ack, respond.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_state     <= W_IDLE;
         aw_full      <= 1'b0;
         w_full       <= 1'b0;
         aw_addr_q    <= '0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
         awready      <= 1'b0;
         wready       <= 1'b0;
         bvalid       <= 1'b0;
         bresp        <= RESP_OKAY;
         user_wr_en   <= 1'b0;
         user_wr_addr <= '0;
         user_wr_data <= '0;
         user_wr_strb <= '0;
      end else begin
         case (wr_state)
            W_IDLE: begin
               if (aw_hs) begin
                  aw_full   <= 1'b1;
                  aw_addr_q <= awaddr;
               end
               if (w_hs) begin
                  w_full   <= 1'b1;
                  w_data_q <= wdata;
                  w_strb_q <= wstrb;
               end
               if (aw_have && w_have) begin
                  awready <= 1'b0;
                  wready  <= 1'b0;
                  if (in_region(wr_addr_sel)) begin
                     wr_state     <= W_ISSUE;
                     user_wr_en   <= 1'b1;
                     user_wr_addr <= region_offset(wr_addr_sel);
                     user_wr_data <= wr_data_sel;
                     user_wr_strb <= wr_strb_sel;
                  end else begin
                     wr_state <= W_RESP;
                     bvalid   <= 1'b1;
                     bresp    <= RESP_DECERR;
                  end
               end else begin
                  awready <= !aw_have;
                  wready  <= !w_have;
               end
            end
            W_ISSUE: begin
               user_wr_en <= 1'b0;
               if (user_wr_ack) begin
                  wr_state <= W_RESP;
                  bvalid   <= 1'b1;
                  bresp    <= user_wr_resp;
               end else begin
                  wr_state <= W_WAIT;
               end
            end
            W_WAIT: begin
               if (user_wr_ack) begin
                  wr_state <= W_RESP;
                  bvalid   <= 1'b1;
                  bresp    <= user_wr_resp;
               end else if (wr_to_expired) begin
                  wr_state <= W_RESP;
                  bvalid   <= 1'b1;
                  bresp    <= RESP_SLVERR;
               end
            end
            W_RESP: begin
               if (bready) begin
                  wr_state <= W_IDLE;
                  bvalid   <= 1'b0;
                  bresp    <= RESP_OKAY;
                  aw_full  <= 1'b0;
                  w_full   <= 1'b0;
                  awready  <= 1'b1;
                  wready   <= 1'b1;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   // ----------------------------------------------------------------- read
   rd_state_t rd_state;
   logic      ar_hs;
   logic      rd_to_run;
   logic      rd_to_expired;

   assign ar_hs     = arvalid && arready;
   assign rd_to_run = (rd_state == R_ISSUE) || (rd_state == R_WAIT);

   axil_timeout_cnt #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rd_timeout (
      .aclk    (aclk),
      .aresetn (aresetn),
      .clr     (!rd_to_run),
      .en      (rd_to_run),
      .expired (rd_to_expired)
   );

   // Read controller: accept AR, issue, await valid, hold data until rready.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_state     <= R_IDLE;
         arready      <= 1'b0;
         rvalid       <= 1'b0;
         rdata        <= '0;
         rresp        <= RESP_OKAY;
         user_rd_en   <= 1'b0;
         user_rd_addr <= '0;
      end else begin
         case (rd_state)
            R_IDLE: begin
               if (ar_hs) begin
                  arready <= 1'b0;
                  if (in_region(araddr)) begin
                     rd_state     <= R_ISSUE;
                     user_rd_en   <= 1'b1;
                     user_rd_addr <= region_offset(araddr);
                  end else begin
                     rd_state <= R_RESP;
                     rvalid   <= 1'b1;
                     rdata    <= '0;
                     rresp    <= RESP_DECERR;
                  end
               end else begin
                  arready <= 1'b1;
               end
            end
            R_ISSUE: begin
               user_rd_en <= 1'b0;
               if (user_rd_valid) begin
                  rd_state <= R_RESP;
                  rvalid   <= 1'b1;
                  rdata    <= user_rd_data;
                  rresp    <= user_rd_resp;
               end else begin
                  rd_state <= R_WAIT;
               end
            end
            R_WAIT: begin
               if (user_rd_valid) begin
                  rd_state <= R_RESP;
                  rvalid   <= 1'b1;
                  rdata    <= user_rd_data;
                  rresp    <= user_rd_resp;
               end else if (rd_to_expired) begin
                  rd_state <= R_RESP;
                  rvalid   <= 1'b1;
                  rdata    <= '0;
                  rresp    <= RESP_SLVERR;
               end
            end
            R_RESP: begin
               if (rready) begin
                  rd_state <= R_IDLE;
                  rvalid   <= 1'b0;
                  rdata    <= '0;
                  rresp    <= RESP_OKAY;
                  arready  <= 1'b1;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_slave_bridge.sv
// Directed bench for axil_slave_bridge. A cycle-indexed expectation table
// is filled from transaction-level rules (handshake cycle, user latency,
// timeout, response hold) and compared against the DUT every cycle.
module tb_axil_slave_bridge;

   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam int          SPAN = 4096;
   localparam int          TO   = 8;
   localparam int          N    = 4096;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [31:0] user_wr_addr;
   logic [31:0] user_wr_data;
   logic [3:0]  user_wr_strb;
   logic        user_wr_en;
   logic        user_wr_ack = 1'b0;
   logic [1:0]  user_wr_resp = '0;
   logic [31:0] user_rd_addr;
   logic        user_rd_en;
   logic        user_rd_valid = 1'b0;
   logic [31:0] user_rd_data = '0;
   logic [1:0]  user_rd_resp = '0;

   axil_slave_bridge #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .BASE_ADDR   (BASE),
      .ADDR_SPAN   (SPAN),
      .TIMEOUT_CYC (TO)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .awaddr        (awaddr),
      .awvalid       (awvalid),
      .awready       (awready),
      .wdata         (wdata),
      .wstrb         (wstrb),
      .wvalid        (wvalid),
      .wready        (wready),
      .bresp         (bresp),
      .bvalid        (bvalid),
      .bready        (bready),
      .araddr        (araddr),
      .arvalid       (arvalid),
      .arready       (arready),
      .rdata         (rdata),
      .rresp         (rresp),
      .rvalid        (rvalid),
      .rready        (rready),
      .user_wr_addr  (user_wr_addr),
      .user_wr_data  (user_wr_data),
      .user_wr_strb  (user_wr_strb),
      .user_wr_en    (user_wr_en),
      .user_wr_ack   (user_wr_ack),
      .user_wr_resp  (user_wr_resp),
      .user_rd_addr  (user_rd_addr),
      .user_rd_en    (user_rd_en),
      .user_rd_valid (user_rd_valid),
      .user_rd_data  (user_rd_data),
      .user_rd_resp  (user_rd_resp)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   // expectation table, indexed by cycle number
   bit          e_wen    [N];
   logic [31:0] e_waddr  [N];
   logic [31:0] e_wdata  [N];
   logic [3:0]  e_wstrb  [N];
   bit          e_bvalid [N];
   logic [1:0]  e_bresp  [N];
   bit          e_ren    [N];
   logic [31:0] e_raddr  [N];
   bit          e_rvalid [N];
   logic [31:0] e_rdata  [N];
   logic [1:0]  e_rresp  [N];

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;
   int ck;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic bit hit(input logic [31:0] a);
      longint x;
      x = longint'(a);
      return (x >= longint'(BASE)) && (x < longint'(BASE) + SPAN);
   endfunction

   // Per-cycle comparison of all response and user-strobe outputs.
   always @(negedge aclk) begin
      if (chk_en && aresetn && cyc < N) begin
         ck = cyc;
         chk("user_wr_en", 64'(user_wr_en), 64'(e_wen[ck]));
         if (e_wen[ck]) begin
            chk("user_wr_addr", 64'(user_wr_addr), 64'(e_waddr[ck]));
            chk("user_wr_data", 64'(user_wr_data), 64'(e_wdata[ck]));
            chk("user_wr_strb", 64'(user_wr_strb), 64'(e_wstrb[ck]));
         end
         chk("bvalid", 64'(bvalid), 64'(e_bvalid[ck]));
         if (e_bvalid[ck]) chk("bresp", 64'(bresp), 64'(e_bresp[ck]));
         chk("user_rd_en", 64'(user_rd_en), 64'(e_ren[ck]));
         if (e_ren[ck]) chk("user_rd_addr", 64'(user_rd_addr), 64'(e_raddr[ck]));
         chk("rvalid", 64'(rvalid), 64'(e_rvalid[ck]));
         if (e_rvalid[ck]) begin
            chk("rdata", 64'(rdata), 64'(e_rdata[ck]));
            chk("rresp", 64'(rresp), 64'(e_rresp[ck]));
         end
      end
   end

   // One write: W at t0+dw, AW at t0+da, ack ackd cycles after the user
   // strobe (-1 = never), bready after bdly cycles of bvalid, optional
   // stray ack stray cycles into the response phase (-1 = none).
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int dw, input int da,
                           input int ackd, input logic [1:0] uresp,
                           input int bdly, input int stray);
      int t0, ca, cw, cb, issue, ackc, rs, re, sc;
      logic [1:0] er;
      t0 = cyc; ca = t0 + da; cw = t0 + dw;
      cb = (ca > cw) ? ca : cw;
      ackc = -1;
      if (hit(addr)) begin
         issue = cb + 1;
         e_wen[issue] = 1'b1; e_waddr[issue] = addr - BASE;
         e_wdata[issue] = data; e_wstrb[issue] = strb;
         if (ackd >= 0 && ackd <= TO) begin
            ackc = issue + ackd; rs = ackc + 1; er = uresp;
         end else begin
            rs = issue + TO + 1; er = 2'b10;
         end
      end else begin
         rs = cb + 1; er = 2'b11;
      end
      re = rs + bdly;
      sc = (stray >= 0) ? rs + stray : -1;
      for (int k = rs; k <= re; k++) begin
         e_bvalid[k] = 1'b1; e_bresp[k] = er;
      end
      for (int k = t0; k <= re + 1; k++) begin
         awvalid = (k == ca); awaddr = addr;
         wvalid = (k == cw); wdata = data; wstrb = strb;
         user_wr_ack = (k == ackc) || (k == sc);
         user_wr_resp = (k == ackc) ? uresp : 2'b01;
         bready = (k == re);
         chk("awready", 64'(awready), 64'((k <= ca) || (k == re + 1)));
         chk("wready", 64'(wready), 64'((k <= cw) || (k == re + 1)));
         if (k < re + 1) begin
            @(posedge aclk); #1;
         end
      end
   endtask

   // One read: AR at t0, user valid vdly cycles after the strobe (-1 = never),
   // rready after rdly cycles of rvalid, optional stray valid in the response.
   task automatic do_read(input logic [31:0] addr, input int vdly,
                          input logic [31:0] data, input logic [1:0] uresp,
                          input int rdly, input int stray);
      int t0, issue, vc, rs, re, sc;
      logic [1:0]  er;
      logic [31:0] ed;
      t0 = cyc; vc = -1;
      if (hit(addr)) begin
         issue = t0 + 1;
         e_ren[issue] = 1'b1; e_raddr[issue] = addr - BASE;
         if (vdly >= 0 && vdly <= TO) begin
            vc = issue + vdly; rs = vc + 1; er = uresp; ed = data;
         end else begin
            rs = issue + TO + 1; er = 2'b10; ed = '0;
         end
      end else begin
         rs = t0 + 1; er = 2'b11; ed = '0;
      end
      re = rs + rdly;
      sc = (stray >= 0) ? rs + stray : -1;
      for (int k = rs; k <= re; k++) begin
         e_rvalid[k] = 1'b1; e_rdata[k] = ed; e_rresp[k] = er;
      end
      for (int k = t0; k <= re + 1; k++) begin
         arvalid = (k == t0); araddr = addr;
         user_rd_valid = (k == vc) || (k == sc);
         user_rd_data = (k == vc) ? data : (32'hBAD0_0000 | 32'(k));
         user_rd_resp = (k == vc) ? uresp : 2'b01;
         rready = (k == re);
         chk("arready", 64'(arready), 64'((k == t0) || (k == re + 1)));
         if (k < re + 1) begin
            @(posedge aclk); #1;
         end
      end
   endtask

   initial begin
      // reset state
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_awready", 64'(awready), 0);
      chk("rst_wready", 64'(wready), 0);
      chk("rst_arready", 64'(arready), 0);
      chk("rst_bvalid", 64'(bvalid), 0);
      chk("rst_rvalid", 64'(rvalid), 0);
      chk("rst_user_wr_en", 64'(user_wr_en), 0);
      chk("rst_user_rd_en", 64'(user_rd_en), 0);
      aresetn = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      chk_en = 1'b1;

      // AW and W together, ack in the issue cycle
      fork
         do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 0, -1);
         begin
            @(posedge aclk); #2;
            chk("pin_wr_en", 64'(user_wr_en), 1);
            chk("pin_wr_addr", 64'(user_wr_addr), 64'h10);
            @(posedge aclk); #2;
            chk("pin_bvalid", 64'(bvalid), 1);
            chk("pin_bresp", 64'(bresp), 0);
         end
      join

      // W three cycles ahead of AW, response held 5 cycles
      do_write(BASE + 32'h24, 32'h0BAD_CAFE, 4'h5, 0, 3, 2, 2'b00, 5, -1);
      // AW ahead of W, wstrb = 0 still issued, EXOKAY passed through
      do_write(BASE + 32'h30, 32'h1111_2222, 4'h0, 2, 0, 1, 2'b01, 1, -1);

      // read with 4-cycle user latency, held while rready low
      fork
         do_read(BASE + 32'h20, 4, 32'h1234_5678, 2'b00, 3, -1);
         begin
            repeat (6) @(posedge aclk);
            #2;
            chk("pin_rvalid", 64'(rvalid), 1);
            chk("pin_rdata", 64'(rdata), 64'h1234_5678);
            chk("pin_rresp", 64'(rresp), 0);
         end
      join

      // out of region on both paths, together with region edges
      fork
         do_write(BASE + SPAN, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 2'b00, 2, -1);
         do_read(BASE + SPAN, 0, 32'hFFFF_FFFF, 2'b00, 1, -1);
      join
      fork
         do_write(BASE - 32'd4, 32'h5555_AAAA, 4'hF, 0, 0, 0, 2'b00, 0, -1);
         do_read(BASE + SPAN - 32'd4, 0, 32'hA5A5_5A5A, 2'b10, 0, -1);
      join

      // timeouts with a late stray ack/valid during the response
      fork
         do_write(BASE + 32'h40, 32'h7777_8888, 4'hF, 0, 0, -1, 2'b00, 3, 1);
         do_read(BASE + 32'h44, -1, 32'h0, 2'b00, 3, 1);
         begin
            repeat (9) @(posedge aclk);
            #2;
            chk("pin_to_bvalid_early", 64'(bvalid), 0);
            @(posedge aclk); #2;
            chk("pin_to_bvalid", 64'(bvalid), 1);
            chk("pin_to_bresp", 64'(bresp), 2'b10);
            chk("pin_to_rresp", 64'(rresp), 2'b10);
         end
      join
      // ack/valid on exactly the last cycle before expiry still wins
      fork
         do_write(BASE + 32'h48, 32'h9999_0000, 4'hC, 0, 0, TO, 2'b00, 0, -1);
         do_read(BASE + 32'h4C, TO, 32'hFEED_F00D, 2'b00, 0, -1);
      join

      // asynchronous reset with write waiting and read response pending
      chk_en = 1'b0;
      awvalid = 1'b1; wvalid = 1'b1; awaddr = BASE + 32'h50;
      wdata = 32'h0102_0304; wstrb = 4'hF;
      arvalid = 1'b1; araddr = BASE + 32'h54;
      @(posedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("rstt_wr_en", 64'(user_wr_en), 1);
      chk("rstt_rd_en", 64'(user_rd_en), 1);
      user_rd_valid = 1'b1; user_rd_data = 32'hCAFE_F00D; user_rd_resp = 2'b00;
      @(posedge aclk); #1;
      user_rd_valid = 1'b0;
      chk("rstt_rvalid", 64'(rvalid), 1);
      chk("rstt_rdata", 64'(rdata), 64'hCAFE_F00D);
      @(posedge aclk); #2;
      chk("rstt_bvalid_wait", 64'(bvalid), 0);
      aresetn = 1'b0;
      #1;
      chk("arst_rvalid", 64'(rvalid), 0);
      chk("arst_rdata", 64'(rdata), 0);
      chk("arst_bvalid", 64'(bvalid), 0);
      chk("arst_awready", 64'(awready), 0);
      chk("arst_wready", 64'(wready), 0);
      chk("arst_arready", 64'(arready), 0);
      chk("arst_wr_addr", 64'(user_wr_addr), 0);
      chk("arst_wr_data", 64'(user_wr_data), 0);
      chk("arst_rd_addr", 64'(user_rd_addr), 0);
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      chk_en = 1'b1;
      do_write(BASE + 32'h58, 32'hABCD_EF01, 4'hF, 0, 0, 2, 2'b00, 0, -1);
      do_read(BASE + 32'h58, 1, 32'h600D_600D, 2'b00, 0, -1);
      repeat (3) @(posedge aclk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
